// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared definitions for the sequential restoring divider.
//                Holds the controller state encoding and the default
//                dividend/divisor widths.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_divider_pkg;

    // Default widths: dividend/quotient and divisor/remainder
    localparam int XW_DEF = 8;
    localparam int YW_DEF = 4;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder, trial-subtracts the
//                divisor and keeps the difference when it is non-negative,
//                otherwise restores the shifted value.
//  Ports       : i_rem     [YW:0]   partial remainder in
//                i_x_bit            next dividend bit (MSB first)
//                i_divisor [YW-1:0] divisor
//                o_rem     [YW:0]   partial remainder out
//                o_q_bit            quotient bit for this step
//  Revision    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int YW = 4
) (
    input  logic [YW:0]   i_rem,
    input  logic          i_x_bit,
    input  logic [YW-1:0] i_divisor,
    output logic [YW:0]   o_rem,
    output logic          o_q_bit
);

    // One extra bit of headroom so the MSB of the difference is a true sign
    // bit: the shifted value is below 2^(YW+1) and the divisor below 2^YW.
    logic [YW+1:0] w_shift;
    logic [YW+1:0] w_diff;
    logic          w_neg;

    assign w_shift = {i_rem, i_x_bit};
    assign w_diff  = w_shift - {2'b00, i_divisor};
    assign w_neg   = w_diff[YW+1];

    assign o_q_bit = ~w_neg;
    assign o_rem   = w_neg ? w_shift[YW:0] : w_diff[YW:0];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential unsigned restoring divider, one quotient bit per
//                clock, MSB first, with valid/ready handshakes on both sides.
//                A zero divisor skips the iterations and returns an all-ones
//                quotient with the low dividend bits as remainder.
//  Ports       : clk, rst (synchronous, active high)
//                x [XW-1:0], y [YW-1:0], in_valid, in_ready  - operand side
//                q [XW-1:0], r [YW-1:0], out_valid, out_ready - result side
//                err (only with SEQ_DIVIDER_DIV0_ERR_EN defined) - result
//                came from a divide by zero
//  Config      : `define SEQ_DIVIDER_DIV0_ERR_EN to add the err output.
//  Constraints : 2 <= XW, 1 <= YW <= XW.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [XW-1:0] q,
    output logic [YW-1:0] r,
    output logic          out_valid,
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
    output logic          err,
`endif
    input  logic          out_ready
);

    localparam int            CW     = $clog2(XW + 1);
    localparam logic [CW-1:0] C_LAST = CW'(XW - 1);

    state_t        r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [XW-1:0] r_q;
    logic [YW-1:0] r_r;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom; after XW steps this register holds the quotient.
    logic [XW-1:0] r_qx;
    logic [YW-1:0] r_y;
    logic [YW:0]   r_rem;
    logic [CW-1:0] r_cnt;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
    logic          r_err;
`endif

    logic [YW:0]   w_rem_next;
    logic          w_q_bit;
    logic [XW-1:0] w_qx_next;
    logic          w_accept;

    assign w_accept  = in_valid && r_in_ready;
    assign w_qx_next = {r_qx[XW-2:0], w_q_bit};

    div_step #(
        .YW (YW)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_x_bit   (r_qx[XW-1]),
        .i_divisor (r_y),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_qx        <= '0;
            r_y         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_qx       <= x;
                        r_y        <= y;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (y == '0) begin
                            // No iterations needed: publish the fixed
                            // divide-by-zero result on the next cycle.
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_q         <= '1;
                            r_r         <= x[YW-1:0];
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
                            r_err       <= 1'b1;
`endif
                        end else begin
                            r_state <= CALC;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
                            r_err   <= 1'b0;
`endif
                        end
                    end
                end

                CALC: begin
                    r_qx  <= w_qx_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        // Final step: capture the step outputs directly so
                        // the result is visible on the XW-th edge.
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_q         <= w_qx_next;
                        r_r         <= w_rem_next[YW-1:0];
                    end
                end

                DONE: begin
                    // in_ready only rises after the hand-off edge, so a new
                    // accept can never share a cycle with a hand-off.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
                        r_err       <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign r         = r_r;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
    assign err       = r_err;
`endif

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider with a result
//                scoreboard fed at operand accept and drained at output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    localparam int XW = 8;
    localparam int YW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] q;
    logic [YW-1:0] r;
    logic          out_valid;
    logic          out_ready;
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
    logic          err;
`endif

    seq_divider #(
        .XW (XW),
        .YW (YW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .out_valid (out_valid),
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
        .err       (err),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0] q;
        logic [YW-1:0] r;
        logic          e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int ax, input int ay);
        exp_t e;
        if (ay == 0) begin
            e.q = '1;
            e.r = YW'(ax % (1 << YW));
            e.e = 1'b1;
        end else begin
            e.q = XW'(ax / ay);
            e.r = YW'(ax % ay);
            e.e = 1'b0;
        end
        return e;
    endfunction

    // Present operands, take the accept edge, record the expected result.
    task automatic accept(input int ax, input int ay, input bit keep);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        x        = XW'(ax);
        y        = YW'(ay);
        in_valid = 1'b1;
        tick();
        sb.push_back(model(ax, ay));
        if (!keep) in_valid = 1'b0;
    endtask

    // Wait for the result, check latency and value, hold it for 'hold'
    // cycles, then hand it off.
    task automatic wait_result(input int exp_lat, input bit churn, input int hold);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 40) begin
            if (churn) begin
                x = XW'($urandom);
                y = YW'($urandom);
                chk("no_accept_in_calc", 32'(in_ready), 32'd0);
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'(exp_lat));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=%0d", sb.size(), 1);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("r", 32'(r), 32'(e.r));
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
            chk("err", 32'(err), 32'(e.e));
`endif
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_q", 32'(q), 32'(e.q));
                chk("hold_r", 32'(r), 32'(e.r));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff_valid", 32'(out_valid), 32'd0);
        chk("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        x         = '0;
        y         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
`ifdef SEQ_DIVIDER_DIV0_ERR_EN
        chk("rst_err", 32'(err), 32'd0);
`endif

        // 100 / 7 = 14 r 2
        accept(100, 7, 1'b0);
        wait_result(XW, 1'b0, 0);

        // Extremes of the dividend
        accept(255, 1, 1'b0);
        wait_result(XW, 1'b0, 0);
        accept(0, 9, 1'b0);
        wait_result(XW, 1'b0, 0);
        accept(255, 15, 1'b0);
        wait_result(XW, 1'b0, 0);

        // Divide by zero: result right after the accept edge
        accept(8'hA5, 0, 1'b0);
        wait_result(0, 1'b0, 2);

        // Back-pressure: out_ready low for 5 cycles in DONE
        accept(200, 15, 1'b0);
        wait_result(XW, 1'b0, 5);

        // Reset after the 4th iteration discards the operation
        accept(77, 5, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_r", 32'(r), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("no_result_after_rst", 32'(out_valid), 32'd0);
        end
        accept(50, 6, 1'b0);
        wait_result(XW, 1'b0, 0);

        // in_valid stays high with changing operands during CALC
        accept(123, 11, 1'b1);
        wait_result(XW, 1'b1, 1);

        // Random operands, zero divisor included when drawn
        for (int i = 0; i < 8; i++) begin
            int ax;
            int ay;
            ax = int'($urandom_range(0, 255));
            ay = int'($urandom_range(0, 15));
            accept(ax, ay, 1'b0);
            wait_result((ay == 0) ? 0 : XW, 1'b0, i % 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter XW, default 8: dividend and quotient width.
REQ-002 SHALL have parameter YW, default 4: divisor and remainder width; legal range YW <= XW.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 x  input  XW  unsigned dividend.
REQ-006 y  input  YW  unsigned divisor.
REQ-007 in_valid  input  1  operands present on x and y.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 q  output  XW  unsigned quotient.
REQ-010 r  output  YW  unsigned remainder.
REQ-011 out_valid  output  1  q and r valid.
REQ-012 out_ready  input  1  consumer accepts the result.

Function
REQ-013 SHALL implement restoring division, one quotient bit per clock, MSB first: partial remainder of YW+1 bits, shift in the next dividend bit, trial-subtract y, keep the difference and set the quotient bit when it is non-negative, else restore.
REQ-014 SHALL use states IDLE, CALC and DONE; IDLE->CALC on an accept, CALC->DONE after XW iterations, DONE->IDLE on out_valid && out_ready.
REQ-015 An accept SHALL occur on a clock edge where in_valid && in_ready; x and y SHALL be registered at that edge and SHALL be ignored thereafter.
REQ-016 in_ready SHALL be 1 only in IDLE; a result is never handed off and new operands accepted in the same cycle.
REQ-017 Latency: out_valid SHALL rise exactly XW clock edges after the accept edge (8 for the defaults).
REQ-018 For y == 0: SHALL go IDLE->DONE in one edge, out_valid SHALL be 1 one cycle after the accept, q = all ones, r = x[YW-1:0].
REQ-019 In DONE, q, r and out_valid SHALL hold stable while out_ready = 0, for any duration.
REQ-020 q and r SHALL satisfy x == q*y + r with r < y for every y != 0, including x = 0 and x = 2^XW-1.
REQ-021 out_valid SHALL be 0 in IDLE and CALC; q and r are don't-care when out_valid = 0.

Reset
REQ-022 With rst = 1 at an edge, SHALL enter IDLE with out_valid = 0, in_ready = 1 and q = r = 0, regardless of the current state.
REQ-023 A reset during CALC or DONE SHALL discard the operation; no result SHALL ever appear for it.

Configuration
REQ-024 Macro SEQ_DIVIDER_DIV0_ERR_EN SHALL control divide-by-zero reporting.
- Defined: adds output port err (1 bit); err = 1 in DONE exactly when the held result came from y == 0, else 0; reset value 0.
- Undefined: no err port exists; all other behaviour is identical, including REQ-018.

Structure
REQ-025 A shared package seq_divider_pkg SHALL hold:
- the state enum (IDLE, CALC, DONE);
- default width constants XW_DEF = 8 and YW_DEF = 4.
REQ-026 The trial subtract and restore SHALL be a combinational sub-module div_step: inputs partial remainder, next dividend bit and divisor; outputs new partial remainder and quotient bit.
REQ-027 The iteration counter SHALL be $clog2(XW+1) bits wide and SHALL clear on accept.

Verification
REQ-028 x = 100, y = 7, accept at edge T0 -> out_valid first 1 after edge T8, q = 14, r = 2.
REQ-029 x = 255, y = 1 -> q = 255, r = 0; then x = 0, y = 9 -> q = 0, r = 0.
REQ-030 x = 0xA5, y = 0 -> out_valid 1 cycle after accept, q = 0xFF, r = 5; err = 1 only with SEQ_DIVIDER_DIV0_ERR_EN defined.
REQ-031 x = 200, y = 15, out_ready held 0 for 5 cycles in DONE -> q = 13 and r = 5 stable, in_ready = 0 throughout; hand-off on the first out_ready = 1 edge, in_ready = 1 the next cycle.
REQ-032 rst pulsed for one edge after the 4th CALC iteration -> next cycle in_ready = 1, out_valid = 0; a following x = 50, y = 6 gives q = 8, r = 2 with full 8-cycle latency.
REQ-033 in_valid held 1 with changing x and y during CALC -> the result reflects only the operands captured at accept, and no second accept occurs before the hand-off.
